uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter that acts as a responder on the core's load/store interface. The core stores bytes into a transmit FIFO, and the block serializes them on a single `tx` line as 8N1 frames at a programmable baud divisor. It sits beside the existing switch/LED/HEX I/O in the LSU address decode. It is the outbound-serial counterpart of the core's memory-mapped I/O: the core initiates, this block responds.

---
 rtl/uart_tx_mmio.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio
// Memory-mapped 8N1 UART transmitter. The core stores bytes into a transmit
// FIFO through a small register window; a four-state FSM serializes them on
// tx, LSB first, at a programmable baud divisor.
//
// Ports
//   clk    system clock, rising edge
//   rst    asynchronous active-low reset
//   addr   byte offset inside the block (bits [3:2] decoded)
//   wdata  store data
//   wren   store strobe
//   rdata  load data, combinational from addr and current state
//   tx     serial line, registered, idle high
//   irq    high while the FIFO is empty and the transmitter is idle
//
// Register map (byte offsets)
//   0x0 TXDATA   write pushes wdata[7:0]; reads 0
//   0x4 STATUS   {count[8:4], overflow[3], empty[2], full[1], busy[0]}
//                writing 1 to bit 3 clears overflow
//   0x8 BAUDDIV  bits [15:0], writes of 0 ignored
//   0xC          unmapped
module uart_tx_mmio #(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter int unsigned DEFAULT_DIV = 434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  addr,
    input  logic [31:0] wdata,
    input  logic        wren,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_s;

    // Control registers
    logic          ovf_r;
    logic [15:0]   baud_r;

    // Transmit FSM
    state_t        state_r;
    state_t        state_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_s;
    logic [15:0]   timer_r;
    logic [15:0]   timer_s;
    logic [15:0]   reload_r;
    logic [15:0]   reload_s;
    logic [2:0]    bit_idx_r;
    logic [2:0]    bit_idx_s;
    logic          tx_r;
    logic          tx_s;
    logic          irq_r;
    logic          irq_s;

    // Decode and handshake
    logic          sel_data_s;
    logic          sel_stat_s;
    logic          sel_div_s;
    logic          push_s;
    logic          push_ok_s;
    logic          drop_s;
    logic          pop_s;
    logic          full_s;
    logic          empty_s;
    logic          busy_s;
    logic [4:0]    count5_s;
    logic          unused_s;

    assign sel_data_s = (addr[3:2] == 2'b00);
    assign sel_stat_s = (addr[3:2] == 2'b01);
    assign sel_div_s  = (addr[3:2] == 2'b10);

    assign full_s   = (count_r == FULL_CNT);
    assign empty_s  = (count_r == {CW{1'b0}});
    assign busy_s   = (state_r != ST_IDLE);
    assign count5_s = 5'(count_r);

    // A push into a full FIFO still lands if the FSM pops on the same edge.
    assign push_s    = wren & sel_data_s;
    assign push_ok_s = push_s & (~full_s | pop_s);
    assign drop_s    = push_s & ~push_ok_s;

    assign unused_s = ^{addr[1:0], wdata[31:16]};

    assign tx  = tx_r;
    assign irq = irq_r;

    // Load data mux over the current register state
    always_comb begin
        rdata = 32'd0;
        case (addr[3:2])
            2'b00:   rdata = 32'd0;
            2'b01:   rdata = {23'd0, count5_s, ovf_r, empty_s, full_s, busy_s};
            2'b10:   rdata = {16'd0, baud_r};
            default: rdata = 32'd0;
        endcase
    end

    // Next FIFO occupancy from accepted pushes and pops
    always_comb begin
        count_s = count_r;
        if (push_ok_s && !pop_s) begin
            count_s = count_r + {{(CW-1){1'b0}}, 1'b1};
        end else if (pop_s && !push_ok_s) begin
            count_s = count_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            count_s = count_r;
        end
    end

    // Transmit FSM next-state, bit timer and shift register
    always_comb begin
        state_s   = state_r;
        shift_s   = shift_r;
        timer_s   = timer_r;
        reload_s  = reload_r;
        bit_idx_s = bit_idx_r;
        pop_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s    = 1'b1;
                    shift_s  = mem_r[rd_ptr_r];
                    reload_s = baud_r;
                    timer_s  = baud_r - 16'd1;
                    state_s  = ST_START;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_START: begin
                if (timer_r == 16'd0) begin
                    state_s   = ST_DATA;
                    bit_idx_s = 3'd0;
                    timer_s   = reload_r - 16'd1;
                end else begin
                    timer_s   = timer_r - 16'd1;
                end
            end
            ST_DATA: begin
                if (timer_r == 16'd0) begin
                    timer_s = reload_r - 16'd1;
                    shift_s = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    timer_s = timer_r - 16'd1;
                end
            end
            ST_STOP: begin
                if (timer_r == 16'd0) begin
                    // Back-to-back: the next start bit begins on this edge.
                    if (!empty_s) begin
                        pop_s    = 1'b1;
                        shift_s  = mem_r[rd_ptr_r];
                        reload_s = baud_r;
                        timer_s  = baud_r - 16'd1;
                        state_s  = ST_START;
                    end else begin
                        state_s  = ST_IDLE;
                    end
                end else begin
                    timer_s = timer_r - 16'd1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Line level and drained flag computed from next state so both register cleanly
    always_comb begin
        tx_s  = 1'b1;
        irq_s = (count_s == {CW{1'b0}}) && (state_s == ST_IDLE);
        case (state_s)
            ST_IDLE:  tx_s = 1'b1;
            ST_START: tx_s = 1'b0;
            ST_DATA:  tx_s = shift_s[0];
            ST_STOP:  tx_s = 1'b1;
            default:  tx_s = 1'b1;
        endcase
    end

    // FSM, FIFO pointers and control registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            shift_r   <= 8'd0;
            timer_r   <= 16'd0;
            reload_r  <= 16'd0;
            bit_idx_r <= 3'd0;
            tx_r      <= 1'b1;
            irq_r     <= 1'b1;
            wr_ptr_r  <= {PW{1'b0}};
            rd_ptr_r  <= {PW{1'b0}};
            count_r   <= {CW{1'b0}};
            ovf_r     <= 1'b0;
            baud_r    <= 16'(DEFAULT_DIV);
        end else begin
            state_r   <= state_s;
            shift_r   <= shift_s;
            timer_r   <= timer_s;
            reload_r  <= reload_s;
            bit_idx_r <= bit_idx_s;
            tx_r      <= tx_s;
            irq_r     <= irq_s;
            count_r   <= count_s;
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end
            // A dropped push wins over a clear on the same edge.
            if (drop_s) begin
                ovf_r <= 1'b1;
            end else if (wren && sel_stat_s && wdata[3]) begin
                ovf_r <= 1'b0;
            end
            if (wren && sel_div_s && (wdata[15:0] != 16'd0)) begin
                baud_r <= wdata[15:0];
            end
        end
    end

    // FIFO storage write port; contents are don't-care while count is zero
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata[7:0];
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic        wren;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    int vectors     = 0;
    int miscompares = 0;

    // Background serial receiver state
    logic       rx_en  = 1'b0;
    int         rx_div = 1;
    logic [8:0] rx_q [$];

    always #5 clk = ~clk;

    uart_tx_mmio #(.FIFO_DEPTH(8), .DEFAULT_DIV(434)) dut (
        .clk   (clk),
        .rst   (rst),
        .addr  (addr),
        .wdata (wdata),
        .wren  (wren),
        .rdata (rdata),
        .tx    (tx),
        .irq   (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wren  = 1'b1;
        @(posedge clk);
        #1;
        wren  = 1'b0;
        wdata = 32'd0;
    endtask

    // Mid-bit sampling receiver; records {stop, data} per frame
    initial begin : rx_proc
        logic [7:0] b;
        int d;
        b = 8'd0;
        forever begin
            @(negedge clk);
            if (rx_en && rst === 1'b1 && tx === 1'b0) begin
                d = rx_div;
                repeat (d / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = tx;
                end
                repeat (d) @(negedge clk);
                rx_q.push_back({tx, b});
            end
        end
    end

    initial begin : stim
        logic [9:0]  fr1;
        logic [19:0] fr2;
        int ones;

        rst = 1'b0; addr = 4'h0; wdata = 32'd0; wren = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_tx", tx, 1'b1);
        chk1("rst_irq", irq, 1'b1);
        chk_reg("rst_status", 4'h4, 32'h0000_0004);
        chk_reg("rst_baud", 4'h8, 32'd434);
        chk_reg("rst_txdata", 4'h0, 32'd0);
        chk_reg("rst_unmapped", 4'hC, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ones = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx === 1'b1) ones++;
        end
        chk("idle_tx_high", 32'(ones), 32'd100);

        // Register writes that must be ignored
        wr(4'h8, 32'd0);
        chk_reg("baud_zero_ignored", 4'h8, 32'd434);
        wr(4'hC, 32'hFFFF_FFFF);
        chk_reg("unmapped_rd", 4'hC, 32'd0);
        chk_reg("unmapped_status", 4'h4, 32'h0000_0004);
        chk_reg("unmapped_baud", 4'h8, 32'd434);

        // Single frame, DIV=4, byte 0x55 (upper wdata bits must be ignored)
        wr(4'h8, 32'hABCD_0004);
        chk_reg("baud4_rd", 4'h8, 32'd4);
        wr(4'h0, 32'h0000_0155);
        addr = 4'h4;
        @(negedge clk);
        chk1("f1_push_tx", tx, 1'b1);
        chk1("f1_push_irq", irq, 1'b0);
        chk("f1_push_status", rdata, 32'h0000_0010);
        fr1 = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk1($sformatf("f1_tx_%0d", i), tx, fr1[i / 4]);
            if (i == 0) chk("f1_status_started", rdata, 32'h0000_0005);
        end
        chk1("f1_irq_before_end", irq, 1'b0);
        @(negedge clk);
        chk1("f1_irq_end", irq, 1'b1);
        chk1("f1_tx_end", tx, 1'b1);
        chk("f1_status_end", rdata, 32'h0000_0004);

        // Back-to-back frames, DIV=2, 0xA5 then 0x3C
        wr(4'h8, 32'd2);
        wr(4'h0, 32'h0000_00A5);
        wr(4'h0, 32'h0000_003C);
        addr = 4'h4;
        fr2 = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk1($sformatf("b2b_tx_%0d", i), tx, fr2[i / 2]);
            chk1($sformatf("b2b_busy_%0d", i), rdata[0], 1'b1);
        end
        @(negedge clk);
        chk1("b2b_tx_end", tx, 1'b1);
        chk("b2b_status_end", rdata, 32'h0000_0004);
        chk1("b2b_irq_end", irq, 1'b1);

        // Overflow: 10 pushes into an 8-deep FIFO while a slow frame runs
        rx_q.delete();
        rx_div = 16;
        rx_en  = 1'b1;
        wr(4'h8, 32'd16);
        for (int i = 0; i < 10; i++) begin
            wr(4'h0, 32'h10 + 32'(i));
        end
        chk_reg("ovf_status", 4'h4, 32'h0000_008B);
        wr(4'h4, 32'hFFFF_FFF7);
        chk_reg("ovf_keep_on_zero", 4'h4, 32'h0000_008B);
        wr(4'h4, 32'h0000_0008);
        chk_reg("ovf_cleared", 4'h4, 32'h0000_0083);
        wr(4'h8, 32'd4);
        rx_div = 4;
        for (int c = 0; c < 1000 && rx_q.size() < 9; c++) @(negedge clk);
        chk("ovf_rx_count", 32'(rx_q.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < rx_q.size()) chk($sformatf("ovf_rx_%0d", i), 32'(rx_q[i]), 32'h110 + 32'(i));
        end
        repeat (10) @(negedge clk);
        chk_reg("ovf_drained_status", 4'h4, 32'h0000_0004);
        rx_en = 1'b0;

        // Divisor change mid-frame takes effect at the next frame
        rx_q.delete();
        rx_div = 8;
        rx_en  = 1'b1;
        wr(4'h8, 32'd8);
        wr(4'h0, 32'h0000_00C3);
        wr(4'h0, 32'h0000_005A);
        repeat (5) @(negedge clk);
        wr(4'h8, 32'd3);
        rx_div = 3;
        chk_reg("div_mid_rd", 4'h8, 32'd3);
        for (int c = 0; c < 400 && rx_q.size() < 2; c++) @(negedge clk);
        chk("div_rx_count", 32'(rx_q.size()), 32'd2);
        if (rx_q.size() > 0) chk("div_rx_0", 32'(rx_q[0]), 32'h0000_01C3);
        if (rx_q.size() > 1) chk("div_rx_1", 32'(rx_q[1]), 32'h0000_015A);
        rx_en = 1'b0;
        repeat (10) @(negedge clk);

        // Reset in the middle of a DATA bit that is low
        wr(4'h8, 32'd8);
        wr(4'h0, 32'h0000_00F0);
        wr(4'h0, 32'h0000_0081);
        addr = 4'h4;
        repeat (9) @(negedge clk);
        chk1("rstmid_pre_tx", tx, 1'b0);
        chk("rstmid_pre_status", rdata, 32'h0000_0011);
        #1;
        rst = 1'b0;
        #1;
        chk1("rstmid_tx", tx, 1'b1);
        chk1("rstmid_irq", irq, 1'b1);
        chk_reg("rstmid_status", 4'h4, 32'h0000_0004);
        chk_reg("rstmid_baud", 4'h8, 32'd434);
        @(negedge clk);
        rst = 1'b1;
        ones = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx === 1'b1) ones++;
        end
        chk("rstmid_no_frame", 32'(ones), 32'd100);
        chk_reg("rstmid_status_after", 4'h4, 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
